// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
//   state_e   : redirect FSM states (RUN / PEND / SQUASH)
//   STG_*     : stage indices of the classic 5-stage pipeline
//   NOP_INSN  : instruction word a flushed pipeline register loads
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,  // normal operation
    ST_PEND   = 2'd1,  // redirect accepted but fetch held; address buffered
    ST_SQUASH = 2'd2   // redirect issued; fetch bubbles cover ROM latency
  } state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hold_merge.sv
// Combinational merge of per-source hold requests.
//   hold_req : per-source request
//   hold_lvl : per-source deepest stage to stall, LVL_W bits per source
//   stall    : stages 0..L hold their value (L = deepest active level)
//   flush    : stage L+1 loads a bubble, when such a stage exists
module pipe_ctrl_hold_merge #(
  parameter int NUM_STAGES   = 5,
  parameter int NUM_HOLD_SRC = 3,
  parameter int LVL_W        = $clog2(NUM_STAGES)
) (
  input  logic [NUM_HOLD_SRC-1:0]       hold_req,
  input  logic [NUM_HOLD_SRC*LVL_W-1:0] hold_lvl,
  output logic [NUM_STAGES-1:0]         stall,
  output logic [NUM_STAGES-1:0]         flush
);

  // Out-of-range levels mean "stall the whole pipe".
  function automatic logic [LVL_W-1:0] clamp(input logic [LVL_W-1:0] v);
    if (int'(v) >= NUM_STAGES) return LVL_W'(NUM_STAGES - 1);
    return v;
  endfunction

  logic                 any_hold;
  logic [LVL_W-1:0]     lvl_max;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    any_hold = |hold_req;
    lvl_max  = '0;
    for (int s = 0; s < NUM_HOLD_SRC; s++) begin
      if (hold_req[s] && (clamp(hold_lvl[s*LVL_W +: LVL_W]) > lvl_max))
        lvl_max = clamp(hold_lvl[s*LVL_W +: LVL_W]);
    end

    stall = '0;
    flush = '0;
    if (any_hold) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stall[k] = (k <= int'(lvl_max));
        flush[k] = (k == int'(lvl_max) + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: hold merge, trap/jump redirect arbitration,
// redirect buffering while fetch is held, and post-redirect fetch squash.
//   clk, rst_n               : clock, asynchronous active-low reset
//   hold_req_i, hold_lvl_i   : per-source hold request and depth
//   jump_flag_i, jump_addr_i : taken jump from JUMP_STAGE
//   trap_flag_i, trap_addr_i : trap/interrupt redirect (wins over jump)
//   stall_o, flush_o         : per-stage stall / bubble controls
//   jump_en_o, jump_addr_o   : one-cycle redirect strobe and target to pc_reg
//   busy_o                   : a redirect is pending or being squashed
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int NUM_HOLD_SRC = 3,
  parameter int JUMP_STAGE   = 2,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int LVL_W        = $clog2(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_HOLD_SRC-1:0]       hold_req_i,
  input  logic [NUM_HOLD_SRC*LVL_W-1:0] hold_lvl_i,
  input  logic                          jump_flag_i,
  input  logic [ADDR_W-1:0]             jump_addr_i,
  input  logic                          trap_flag_i,
  input  logic [ADDR_W-1:0]             trap_addr_i,
  output logic [NUM_STAGES-1:0]         stall_o,
  output logic [NUM_STAGES-1:0]         flush_o,
  output logic                          jump_en_o,
  output logic [ADDR_W-1:0]             jump_addr_o,
  output logic                          busy_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [NUM_STAGES-1:0] hold_stall, hold_flush;
  logic [NUM_STAGES-1:0] stall_c, flush_c;

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pend_addr;

  logic              fetch_held;
  logic              trap_acc, jump_acc, redir;
  logic [ADDR_W-1:0] redir_addr;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  pipe_ctrl_hold_merge #(
    .NUM_STAGES  (NUM_STAGES),
    .NUM_HOLD_SRC(NUM_HOLD_SRC),
    .LVL_W       (LVL_W)
  ) u_hold_merge (
    .hold_req(hold_req_i),
    .hold_lvl(hold_lvl_i),
    .stall   (hold_stall),
    .flush   (hold_flush)
  );

  // Qualification uses the raw hold stall: the redirect flush below depends
  // on acceptance, so using the final stall here would form a loop.
  assign fetch_held = hold_stall[STG_IF];
  assign trap_acc   = trap_flag_i;
  assign jump_acc   = jump_flag_i && !hold_stall[JUMP_STAGE] && (state != ST_PEND);
  assign redir      = trap_acc || jump_acc;
  assign redir_addr = trap_acc ? trap_addr_i : jump_addr_i;

  always_comb begin
    issue      = 1'b0;
    issue_addr = redir_addr;
    flush_c    = hold_flush;

    if (state == ST_PEND) begin
      issue      = !fetch_held;
      // A trap arriving on the release cycle supersedes the buffered target.
      issue_addr = trap_acc ? trap_addr_i : pend_addr;
      if (issue) flush_c[STG_ID] = 1'b1;
    end else begin
      issue = redir && !fetch_held;
    end

    if (redir) begin
      for (int k = 1; k <= JUMP_STAGE; k++) flush_c[k] = 1'b1;
    end
    if (state == ST_SQUASH) flush_c[STG_ID] = 1'b1;

    // A stage being flushed must load the bubble, not keep its old value.
    stall_c = hold_stall & ~flush_c;
  end

  // Outputs are forced low while reset is asserted, even with holds active.
  assign stall_o     = rst_n ? stall_c : '0;
  assign flush_o     = rst_n ? flush_c : '0;
  assign jump_en_o   = rst_n && issue;
  assign jump_addr_o = (rst_n && issue) ? issue_addr : '0;
  assign busy_o      = rst_n && (state != ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      cnt       <= '0;
      pend_addr <= '0;
    end else begin
      case (state)
        ST_PEND: begin
          if (trap_acc) pend_addr <= trap_addr_i;
          if (!fetch_held) begin
            if (FLUSH_CYCLES > 1) begin
              state <= ST_SQUASH;
              cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state <= ST_RUN;
            end
          end
        end
        default: begin  // ST_RUN and ST_SQUASH
          if (redir) begin
            if (fetch_held) begin
              state     <= ST_PEND;
              pend_addr <= redir_addr;
            end else if (FLUSH_CYCLES > 1) begin
              state <= ST_SQUASH;
              cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state <= ST_RUN;
            end
          end else if (state == ST_SQUASH) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule
